// File: rtl/mem_stall_ctrl_pkg.sv
// rtl/mem_stall_ctrl_pkg.sv - shared pipeline constants for the memory stall controller
package mem_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_t;

    localparam int DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/mem_stall_ctrl.sv
// rtl/mem_stall_ctrl.sv - pipeline stall/flush control with memory-access timeout
// Optional stall-cycle counter: MEM_STALL_CTRL_STALL_COUNT_EN
module mem_stall_ctrl
    import mem_stall_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic        memReady,
    input  logic        loadUse,
    input  logic        branchTaken,
    output logic        pcWrite,
    output logic        ifIdWrite,
    output logic        idExWrite,
    output logic        exMemWrite,
    output logic        ifIdFlush,
    output logic        idExFlush,
    output logic        memWbBubble,
    output logic        memErr,
    output logic [31:0] stallCycles
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t     state;
    state_t     next_state;
    state_t     cur;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_inc;
    logic       mem_stall;

    // During the reset cycle the outputs behave as if already in IDLE
    assign cur          = rst ? IDLE : state;
    assign wait_cnt_inc = wait_cnt + 8'd1;
    assign mem_stall    = (memRead | memWrite) & ~memReady & (cur != ERR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
            memErr   <= 1'b0;
        end else begin
            state  <= next_state;
            memErr <= memErr | (next_state == ERR);
            if (state == WAIT && next_state == WAIT) begin
                wait_cnt <= wait_cnt_inc;
            end else begin
                wait_cnt <= 8'd0;
            end
        end
    end

    always_comb begin
        next_state  = cur;
        pcWrite     = 1'b1;
        ifIdWrite   = 1'b1;
        idExWrite   = 1'b1;
        exMemWrite  = 1'b1;
        ifIdFlush   = 1'b0;
        idExFlush   = 1'b0;
        memWbBubble = 1'b0;

        case (cur)
            IDLE: begin
                if (mem_stall) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (memReady) begin
                    next_state = IDLE;
                end else if (wait_cnt_inc == TIMEOUT_C) begin
                    next_state = ERR;
                end
            end
            ERR: begin
                next_state = ERR;
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        // Priority: error, memory stall, taken branch, load-use
        if (cur == ERR || mem_stall) begin
            pcWrite     = 1'b0;
            ifIdWrite   = 1'b0;
            idExWrite   = 1'b0;
            exMemWrite  = 1'b0;
            memWbBubble = 1'b1;
        end else if (branchTaken) begin
            ifIdFlush   = 1'b1;
            idExFlush   = 1'b1;
        end else if (loadUse) begin
            pcWrite     = 1'b0;
            ifIdWrite   = 1'b0;
            idExFlush   = 1'b1;
        end
    end

`ifdef MEM_STALL_CTRL_STALL_COUNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 32'd0;
        end else if (mem_stall && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stallCycles = stall_cnt;
`else
    assign stallCycles = 32'd0;
`endif

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// tb/tb_mem_stall_ctrl.sv - table-driven scoreboard bench for mem_stall_ctrl
module tb_mem_stall_ctrl;

    typedef struct {
        logic        rst;
        logic        rd;
        logic        wr;
        logic        rdy;
        logic        lu;
        logic        br;
        logic [6:0]  exp_o;
        logic        exp_err;
        logic [31:0] exp_sc;
        string       tag;
    } vec_t;

    // {pcWrite, ifIdWrite, idExWrite, exMemWrite, ifIdFlush, idExFlush, memWbBubble}
    localparam logic [6:0] NORM = 7'b1111000;
    localparam logic [6:0] STL  = 7'b0000001;
    localparam logic [6:0] LU   = 7'b0011010;
    localparam logic [6:0] BR   = 7'b1111110;

    logic        clk = 1'b0;
    logic        rst, memRead, memWrite, memReady, loadUse, branchTaken;
    logic        pcWrite, ifIdWrite, idExWrite, exMemWrite;
    logic        ifIdFlush, idExFlush, memWbBubble, memErr;
    logic [31:0] stallCycles;

    int   n_vec = 0;
    int   n_bad = 0;
    vec_t sb[$];
    vec_t tbl[21];

    mem_stall_ctrl #(.TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .memRead(memRead), .memWrite(memWrite), .memReady(memReady),
        .loadUse(loadUse), .branchTaken(branchTaken),
        .pcWrite(pcWrite), .ifIdWrite(ifIdWrite),
        .idExWrite(idExWrite), .exMemWrite(exMemWrite),
        .ifIdFlush(ifIdFlush), .idExFlush(idExFlush),
        .memWbBubble(memWbBubble), .memErr(memErr),
        .stallCycles(stallCycles)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] esc(input int n);
`ifdef MEM_STALL_CTRL_STALL_COUNT_EN
        return 32'(n);
`else
        return (n == 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    function automatic vec_t mk(input logic r, input logic rd, input logic wr,
                                input logic rdy, input logic lu, input logic br,
                                input logic [6:0] o, input logic e,
                                input logic [31:0] sc, input string tag);
        vec_t v;
        v.rst = r; v.rd = rd; v.wr = wr; v.rdy = rdy; v.lu = lu; v.br = br;
        v.exp_o = o; v.exp_err = e; v.exp_sc = sc; v.tag = tag;
        return v;
    endfunction

    task automatic check();
        vec_t       e;
        logic [6:0] o;
        e = sb.pop_front();
        o = {pcWrite, ifIdWrite, idExWrite, exMemWrite, ifIdFlush, idExFlush, memWbBubble};
        n_vec++;
        if (o !== e.exp_o) begin
            n_bad++;
            $display("FAIL %s outputs: got %b want %b", e.tag, o, e.exp_o);
        end
        n_vec++;
        if (memErr !== e.exp_err) begin
            n_bad++;
            $display("FAIL %s memErr: got %b want %b", e.tag, memErr, e.exp_err);
        end
        n_vec++;
        if (stallCycles !== e.exp_sc) begin
            n_bad++;
            $display("FAIL %s stallCycles: got %0d want %0d", e.tag, stallCycles, e.exp_sc);
        end
    endtask

    task automatic apply(input vec_t v);
        rst = v.rst; memRead = v.rd; memWrite = v.wr; memReady = v.rdy;
        loadUse = v.lu; branchTaken = v.br;
        sb.push_back(v);
        @(negedge clk);
        check();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = mk(1,0,0,0,0,0, NORM, 0, esc(0), "reset");
        tbl[1]  = mk(0,0,0,0,0,0, NORM, 0, esc(0), "idle");
        tbl[2]  = mk(0,1,0,1,0,0, NORM, 0, esc(0), "rd_ready_same_cycle");
        tbl[3]  = mk(0,0,0,0,0,0, NORM, 0, esc(0), "stays_idle");
        tbl[4]  = mk(0,0,1,0,0,0, STL,  0, esc(0), "wr_stall1");
        tbl[5]  = mk(0,0,1,0,0,0, STL,  0, esc(1), "wr_stall2");
        tbl[6]  = mk(0,0,1,0,0,0, STL,  0, esc(2), "wr_stall3");
        tbl[7]  = mk(0,0,1,1,0,0, NORM, 0, esc(3), "wr_release");
        tbl[8]  = mk(0,0,0,0,0,0, NORM, 0, esc(3), "after_wr");
        tbl[9]  = mk(0,0,0,0,1,0, LU,   0, esc(3), "load_use");
        tbl[10] = mk(0,0,0,0,0,0, NORM, 0, esc(3), "load_use_gone");
        tbl[11] = mk(0,0,0,0,0,1, BR,   0, esc(3), "branch");
        tbl[12] = mk(0,0,0,0,1,1, BR,   0, esc(3), "branch_over_lu");
        tbl[13] = mk(0,1,0,0,1,1, STL,  0, esc(3), "stall_over_hazard1");
        tbl[14] = mk(0,1,0,0,1,1, STL,  0, esc(4), "stall_over_hazard2");
        tbl[15] = mk(0,1,0,1,1,1, BR,   0, esc(5), "flush_at_release");
        tbl[16] = mk(0,0,0,0,1,1, BR,   0, esc(5), "flush_after_release");
        tbl[17] = mk(0,0,0,0,0,0, NORM, 0, esc(5), "quiet");
        tbl[18] = mk(0,1,1,0,0,0, STL,  0, esc(5), "rd_wr_both_stall");
        tbl[19] = mk(0,1,1,1,0,0, NORM, 0, esc(6), "rd_wr_both_release");
        tbl[20] = mk(0,0,0,0,0,0, NORM, 0, esc(6), "quiet2");

        rst = 1'b1; memRead = 1'b0; memWrite = 1'b0; memReady = 1'b0;
        loadUse = 1'b0; branchTaken = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;

        for (int i = 0; i < 21; i++) apply(tbl[i]);

        // Timeout: one IDLE stall cycle plus 15 WAIT cycles, then ERR
        for (int i = 0; i < 16; i++) apply(mk(0,1,0,0,0,0, STL, 0, esc(6 + i), "timeout_wait"));
        apply(mk(0,1,0,0,1,1, STL,  1, esc(22), "err_entered"));
        apply(mk(0,1,0,1,0,0, STL,  1, esc(22), "err_absorbing"));
        apply(mk(0,0,0,0,0,1, STL,  1, esc(22), "err_ignores_branch"));
        apply(mk(1,0,0,0,0,0, NORM, 1, esc(22), "rst_in_err"));
        apply(mk(0,0,0,0,0,0, NORM, 0, esc(0),  "after_err_rst"));

        // Reset in the middle of WAIT
        apply(mk(0,1,0,0,0,0, STL,  0, esc(0), "mid_wait1"));
        apply(mk(0,1,0,0,0,0, STL,  0, esc(1), "mid_wait2"));
        apply(mk(1,1,0,0,0,0, STL,  0, esc(2), "rst_cycle_idle_outputs"));
        apply(mk(0,0,0,0,0,0, NORM, 0, esc(0), "after_wait_rst"));
        apply(mk(0,1,0,0,0,0, STL,  0, esc(0), "fresh_stall"));
        apply(mk(0,1,0,1,0,0, NORM, 0, esc(1), "fresh_release"));
        apply(mk(0,0,0,0,0,0, NORM, 0, esc(1), "final_idle"));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
